// File: rtl/nios2_debug_cmd_sysclk_gen.sv
// System-clock side of the Nios II debug slave: synchronises the JTAG update
// strobes, captures IR/DR, decodes action strobes and queues commands in a FIFO.
module nios2_debug_cmd_sysclk_gen #(
  parameter int IR_WIDTH    = 2,
  parameter int DR_WIDTH    = 38,
  parameter int ACT_BIT     = 37,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vs_uir,
  input  logic                            vs_udr,
  input  logic [IR_WIDTH-1:0]             ir_in,
  input  logic [DR_WIDTH-1:0]             sr,
  input  logic                            cmd_ready,
  input  logic                            ovf_clr,
  output logic [IR_WIDTH-1:0]             ir_latched,
  output logic [DR_WIDTH-1:0]             jdo,
  output logic [(2**IR_WIDTH)-1:0]        take_action,
  output logic [(2**IR_WIDTH)-1:0]        take_no_action,
  output logic                            cmd_valid,
  output logic [IR_WIDTH-1:0]             cmd_ir,
  output logic                            cmd_act,
  output logic [DR_WIDTH-1:0]             cmd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);

  localparam int NL = 2**IR_WIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int EW = IR_WIDTH + 1 + DR_WIDTH;

  logic [SYNC_STAGES-1:0] uirSync_q, udrSync_q, prime_q;
  logic                   uirD_q, udrD_q, uirArm_q, udrArm_q;
  logic                   uirLvl, udrLvl, primed, uirRise, udrRise;

  // prime_q marks when the synchroniser outputs carry real post-reset samples,
  // so a strobe held high through reset cannot arm itself from cleared flops.
  assign uirLvl  = uirSync_q[SYNC_STAGES-1];
  assign udrLvl  = udrSync_q[SYNC_STAGES-1];
  assign primed  = prime_q[SYNC_STAGES-1];
  assign uirRise = uirLvl & ~uirD_q & uirArm_q;
  assign udrRise = udrLvl & ~udrD_q & udrArm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uirSync_q <= '0;
      udrSync_q <= '0;
      prime_q   <= '0;
      uirD_q    <= 1'b0;
      udrD_q    <= 1'b0;
      uirArm_q  <= 1'b0;
      udrArm_q  <= 1'b0;
    end else begin
      uirSync_q <= {uirSync_q[SYNC_STAGES-2:0], vs_uir};
      udrSync_q <= {udrSync_q[SYNC_STAGES-2:0], vs_udr};
      prime_q   <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      uirD_q    <= uirLvl;
      udrD_q    <= udrLvl;
      uirArm_q  <= uirArm_q | (primed & ~uirLvl);
      udrArm_q  <= udrArm_q | (primed & ~udrLvl);
    end
  end

  logic [IR_WIDTH-1:0] irLatched_q, irLatched_d;
  logic [DR_WIDTH-1:0] jdo_q, jdo_d;
  logic [NL-1:0]       takeAct_q, takeAct_d, takeNo_q, takeNo_d, lineSel;
  logic                udrAct;

  assign udrAct  = sr[ACT_BIT];
  assign lineSel = NL'(1) << irLatched_q;

  // The udr decode reads the old irLatched_q, so a coincident uir update only
  // takes effect for the following command.
  always_comb begin
    irLatched_d = irLatched_q;
    jdo_d       = jdo_q;
    takeAct_d   = '0;
    takeNo_d    = '0;
    if (uirRise) irLatched_d = ir_in;
    if (udrRise) begin
      jdo_d = sr;
      if (udrAct) takeAct_d = lineSel;
      else        takeNo_d  = lineSel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irLatched_q <= '0;
      jdo_q       <= '0;
      takeAct_q   <= '0;
      takeNo_q    <= '0;
    end else begin
      irLatched_q <= irLatched_d;
      jdo_q       <= jdo_d;
      takeAct_q   <= takeAct_d;
      takeNo_q    <= takeNo_d;
    end
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, valid, push, pop, drop;
  logic [EW-1:0] entry, head;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign valid = (count_q != '0);
  assign pop   = valid & cmd_ready;
  assign push  = udrRise & (~full | pop);
  assign drop  = udrRise & full & ~pop;
  assign entry = {irLatched_q, udrAct, sr};
  assign head  = mem_q[rdPtr_q];

  // When full with a simultaneous pop, the write slot equals the slot being
  // vacated, so the new entry lands at the tail after the pointer moves.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = (wrPtr_q == AW'(FIFO_DEPTH-1)) ? '0 : wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = (rdPtr_q == AW'(FIFO_DEPTH-1)) ? '0 : rdPtr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) mem_q[wrPtr_q] <= entry;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ir_latched     = irLatched_q;
  assign jdo            = jdo_q;
  assign take_action    = takeAct_q;
  assign take_no_action = takeNo_q;
  assign cmd_valid      = valid;
  assign cmd_ir         = head[EW-1 -: IR_WIDTH];
  assign cmd_act        = head[DR_WIDTH];
  assign cmd_data       = head[DR_WIDTH-1:0];
  assign fifo_count     = count_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_nios2_debug_cmd_sysclk_gen.sv
// Directed plus randomized bench for nios2_debug_cmd_sysclk_gen, checked
// against a queue-based command model with immediate assertions.
module tb_nios2_debug_cmd_sysclk_gen;

  localparam int IRW = 2;
  localparam int DRW = 38;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           vs_uir, vs_udr, cmd_ready, ovf_clr;
  logic [IRW-1:0] ir_in;
  logic [DRW-1:0] sr;
  logic [IRW-1:0] ir_latched, cmd_ir;
  logic [DRW-1:0] jdo, cmd_data;
  logic [3:0]     take_action, take_no_action;
  logic           cmd_valid, cmd_act, overflow;
  logic [2:0]     fifo_count;

  nios2_debug_cmd_sysclk_gen dut (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
    .ir_latched(ir_latched), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .cmd_valid(cmd_valid), .cmd_ir(cmd_ir),
    .cmd_act(cmd_act), .cmd_data(cmd_data), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFail = 0;

  // Reference model: queue of {ir, act, data} commands plus latched state.
  logic [IRW+DRW:0] expQ[$];
  logic [IRW-1:0]   expIr;
  logic [DRW-1:0]   expJdo;
  logic [3:0]       expTA, expTN;
  logic             expOvf;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkHead(input string tag);
    chk({tag, ".count"}, 64'(fifo_count), 64'(expQ.size()));
    chk({tag, ".ovf"}, 64'(overflow), 64'(expOvf));
    if (expQ.size() > 0) begin
      chk({tag, ".valid"}, 64'(cmd_valid), 64'd1);
      chk({tag, ".head"}, 64'({cmd_ir, cmd_act, cmd_data}), 64'(expQ[0]));
    end else begin
      chk({tag, ".valid"}, 64'(cmd_valid), 64'd0);
    end
  endtask

  task automatic modelUdr(input logic [DRW-1:0] data);
    logic act;
    act    = data[DRW-1];
    expJdo = data;
    expTA  = act ? (4'b0001 << expIr) : 4'b0000;
    expTN  = act ? 4'b0000 : (4'b0001 << expIr);
    if (expQ.size() < DEPTH) expQ.push_back({expIr, act, data});
    else                     expOvf = 1'b1;
  endtask

  task automatic checkStrobes(input string tag);
    chk({tag, ".ta"}, 64'(take_action), 64'(expTA));
    chk({tag, ".tn"}, 64'(take_no_action), 64'(expTN));
    chk({tag, ".jdo"}, 64'(jdo), 64'(expJdo));
    chk({tag, ".irl"}, 64'(ir_latched), 64'(expIr));
  endtask

  task automatic checkQuiet(input string tag);
    chk({tag, ".ta0"}, 64'(take_action), 64'd0);
    chk({tag, ".tn0"}, 64'(take_no_action), 64'd0);
  endtask

  task automatic uirPulse(input logic [IRW-1:0] ir);
    ir_in = ir; vs_uir = 1'b1;
    repeat (3) tick();
    expIr = ir;
    chk("uir.irl", 64'(ir_latched), 64'(expIr));
    checkQuiet("uir");
    tick();
    vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  task automatic udrPulse(input string tag, input logic [DRW-1:0] data,
                          input bit popAt, input bit clrAt);
    sr = data; vs_udr = 1'b1;
    tick(); tick();
    if (popAt) begin
      checkHead({tag, ".prepop"});
      cmd_ready = 1'b1;
      if (expQ.size() > 0) void'(expQ.pop_front());
    end
    if (clrAt) begin
      ovf_clr = 1'b1;
      expOvf  = 1'b0;
    end
    tick();
    cmd_ready = 1'b0; ovf_clr = 1'b0;
    modelUdr(data);
    checkStrobes(tag);
    checkHead(tag);
    tick();
    checkQuiet(tag);
    vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic popOne(input string tag);
    checkHead({tag, ".pre"});
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    if (expQ.size() > 0) void'(expQ.pop_front());
    checkHead(tag);
  endtask

  task automatic clearOvf();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    expOvf = 1'b0;
    chk("clr.ovf", 64'(overflow), 64'd0);
  endtask

  task automatic modelReset();
    expQ.delete();
    expIr = '0; expJdo = '0; expTA = '0; expTN = '0; expOvf = 1'b0;
  endtask

  initial begin
    logic [63:0] rnd;
    reset = 1'b1; vs_uir = 1'b0; vs_udr = 1'b0; cmd_ready = 1'b0;
    ovf_clr = 1'b0; ir_in = '0; sr = '0;
    modelReset();
    repeat (3) tick();
    checkStrobes("rst");
    checkHead("rst");
    reset = 1'b0;
    repeat (4) tick();

    $display("[TB] basic action and no-action commands");
    uirPulse(2'b01);
    udrPulse("act", 38'h20_0000_00AB, 0, 0);
    uirPulse(2'b11);
    udrPulse("noact", 38'h00_1234_5678, 0, 0);
    popOne("pop.a"); popOne("pop.b"); popOne("pop.empty");

    $display("[TB] overflow and drain");
    for (int i = 1; i <= 5; i++) udrPulse("fill", DRW'(i), 0, 0);
    for (int i = 0; i < 5; i++) popOne("drain");
    udrPulse("fill.clrdrop", 38'h1, 0, 0);
    clearOvf();
    for (int i = 0; i < 3; i++) udrPulse("fill2", DRW'(16 + i), 0, 0);
    udrPulse("fill2.last", 38'h20_0000_0013, 0, 0);
    udrPulse("full.drop.clr", 38'h55, 0, 1);
    clearOvf();
    udrPulse("full.pushpop", 38'h20_0000_0099, 1, 0);
    for (int i = 0; i < 4; i++) popOne("drain2");

    $display("[TB] strobe held through reset");
    sr = 38'h20_0000_0077; vs_udr = 1'b1;
    repeat (3) tick();
    modelUdr(sr);
    checkStrobes("prerst");
    reset = 1'b1;
    #1;
    modelReset();
    checkStrobes("asyncrst");
    checkHead("asyncrst");
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkQuiet("held");
      chk("held.count", 64'(fifo_count), 64'd0);
    end
    vs_udr = 1'b0;
    repeat (3) tick();
    udrPulse("rearm", 38'h20_0000_0042, 0, 0);
    repeat (4) tick();
    checkHead("rearm.once");
    popOne("rearm.pop");

    $display("[TB] simultaneous uir and udr");
    uirPulse(2'b00);
    ir_in = 2'b10; sr = 38'h20_0000_0ABC; vs_uir = 1'b1; vs_udr = 1'b1;
    repeat (3) tick();
    modelUdr(sr);
    expIr = 2'b10;
    checkStrobes("both");
    checkHead("both");
    tick();
    checkQuiet("both");
    vs_uir = 1'b0; vs_udr = 1'b0;
    repeat (3) tick();
    popOne("both.pop");

    $display("[TB] randomized commands");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: uirPulse(IRW'($urandom_range(0, 3)));
        1, 2: begin
          rnd = {$urandom(), $urandom()};
          udrPulse("rnd.udr", rnd[DRW-1:0], bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 3) == 0));
        end
        3: popOne("rnd.pop");
        default: clearOvf();
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/nios2_debug_cmd_sysclk_gen.md
Name: nios2_debug_cmd_sysclk_gen

Overview:
Parametrised system-clock side of the Nios II debug slave. It synchronises the virtual-JTAG update strobes (vs_uir, vs_udr) from the TCK domain and captures the instruction register and the data shift register. It decodes each update into one-hot take_action / take_no_action strobes. It also queues every captured command in a show-ahead FIFO with ready/valid backpressure for OCI consumers.

Parameters:
IR_WIDTH, 2, instruction register width; 2**IR_WIDTH decoded strobe lines
DR_WIDTH, 38, data shift register width
ACT_BIT, 37, bit of sr selecting action (1) vs no-action (0); must be < DR_WIDTH
SYNC_STAGES, 2, synchroniser flops per strobe; minimum 2
FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vs_uir  in  1  update-IR strobe, asynchronous, held high >= SYNC_STAGES+1 clk cycles
vs_udr  in  1  update-DR strobe, asynchronous, same hold rule
ir_in  in  IR_WIDTH  instruction, stable while vs_uir is high
sr  in  DR_WIDTH  shift register contents, stable while vs_udr is high
cmd_ready  in  1  consumer accepts head entry
ovf_clr  in  1  clears overflow
ir_latched  out  IR_WIDTH  last captured instruction
jdo  out  DR_WIDTH  last captured data
take_action  out  2**IR_WIDTH  one-hot, one-cycle pulse
take_no_action  out  2**IR_WIDTH  one-hot, one-cycle pulse
cmd_valid  out  1  FIFO non-empty
cmd_ir  out  IR_WIDTH  head entry instruction
cmd_act  out  1  head entry action bit
cmd_data  out  DR_WIDTH  head entry data
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy
overflow  out  1  sticky, set when a command is dropped

Behaviour:
- Reset: all outputs 0; synchronisers, edge flops, arm flags and FIFO pointers cleared.
- Synchroniser: each strobe passes through SYNC_STAGES flops. Edge flop d follows the synchroniser output. rise = sync & ~d & armed.
- Arm flag, one per strobe: cleared by reset; set on the first cycle the synchronised strobe is 0. A strobe already high at reset release is therefore ignored until it returns low.
- Latency: a strobe sampled high at edge 1 produces rise during the cycle after edge SYNC_STAGES. Its effects register at edge SYNC_STAGES+1.
- On uir rise: ir_latched <= ir_in.
- On udr rise, all on the same edge:
  - jdo <= sr.
  - If sr[ACT_BIT]=1, take_action[ir_latched] = 1; otherwise take_no_action[ir_latched] = 1.
  - FIFO push of {ir_latched, sr[ACT_BIT], sr}.
- take_* strobes are high exactly one cycle and are never both nonzero.
- Simultaneous uir and udr rise: the udr event uses the previous ir_latched; ir_latched then updates.
- FIFO:
  - Show-ahead; cmd_* reflect the head entry; cmd_valid = (fifo_count != 0).
  - Pop when cmd_valid & cmd_ready. cmd_ready while empty is ignored.
  - Push while full with simultaneous pop: accepted; count unchanged.
  - Push while full without pop: entry dropped and overflow <= 1. take_* and jdo still update.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_* hold their last values when empty (don't-care for checking).
- overflow: cleared by ovf_clr. If ovf_clr and a new drop occur in the same cycle, overflow stays 1.
- Reset mid-operation: pending strobes lost, FIFO emptied, take_* deasserted immediately (asynchronous).

Test Plan:
- Reset release; vs_uir high 4 cycles with ir_in=2'b01; then vs_udr high 4 cycles with sr=38'h20_0000_00AB -> 3 edges after udr sampled: jdo=38'h20_0000_00AB, take_action=4'b0010 for 1 cycle, cmd_valid=1, cmd_ir=1, cmd_act=1, fifo_count=1.
- ir_in=2'b11, sr=38'h00_1234_5678 (bit37=0) -> take_no_action=4'b1000 for 1 cycle, take_action=0, cmd_act=0.
- cmd_ready=0, five udr events with sr=1..5 -> fifo_count=4, overflow=1, take_* pulsed 5 times; then cmd_ready=1 -> cmd_data pops 1,2,3,4 in order, cmd_valid=0 after.
- FIFO full, udr rise in the same cycle as cmd_ready=1 -> fifo_count stays 4, overflow stays 0, new entry appears at the tail.
- vs_udr held high across reset deassertion -> no take_* and no push; drive low 3 cycles then high -> exactly one command.
- vs_uir and vs_udr rise together with ir_latched=2'b00, ir_in=2'b10 -> cmd_ir=0 and take_* bit 0 pulses; ir_latched=2'b10 afterward.
